// File: rtl/tsxb_fpga_zbus_slave.sv
// ZX-BUS slave endpoint behind the TSXB CPLD: demuxes the time-shared host address,
// decodes one I/O port family and bridges host I/O cycles onto a register-file strobe pair.
`timescale 1ns / 1ps

module tsxb_fpga_zbus_slave #(
  parameter logic [7:0]  PORT_LO     = 8'hBF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       master_mode,
  input  logic [7:0] fa,
  input  logic       fa_sel,
  input  logic       frd_n,
  input  logic       fwr_n,
  input  logic       fiorq_n,
  input  logic [7:0] zd_in,
  output logic [7:0] zd_out,
  output logic       zd_oe,
  output logic       fiorge_n,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StHit, StRdWait, StRdCap, StRdHold, StWrWait, StMiss, StEnd
  } state_e;

  state_e                 state_q;
  logic                   cap_cnt_q;
  logic                   armed_q;
  logic [7:0]             fa_q, ah_q, al_q;
  logic                   fa_sel_q;
  logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q, iorq_sync_q;
  logic                   rd_s, wr_s, iorq_s;

  assign rd_s   = rd_sync_q[SYNC_STAGES-1];
  assign wr_s   = wr_sync_q[SYNC_STAGES-1];
  assign iorq_s = iorq_sync_q[SYNC_STAGES-1];

  // IORQ resets to its asserted level so a cycle already in progress at reset release
  // is never picked up half-way; the block must first see IORQ inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
      iorq_sync_q <= '0;
    end else begin
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], frd_n};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], fwr_n};
      iorq_sync_q <= {iorq_sync_q[SYNC_STAGES-2:0], fiorq_n};
    end
  end

  // fa/fa_sel come from the same clock domain, so a plain register is enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_q     <= '0;
      fa_sel_q <= 1'b0;
      ah_q     <= '0;
      al_q     <= '0;
    end else begin
      fa_q     <= fa;
      fa_sel_q <= fa_sel;
      if (fa_sel_q) ah_q <= fa_q;
      else          al_q <= fa_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cap_cnt_q <= 1'b0;
      armed_q   <= 1'b0;
      fiorge_n  <= 1'b1;
      zd_oe     <= 1'b0;
      zd_out    <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (master_mode) begin
        state_q  <= StIdle;
        armed_q  <= 1'b0;
        fiorge_n <= 1'b1;
        zd_oe    <= 1'b0;
      end else begin
        if (iorq_s) armed_q <= 1'b1;
        unique case (state_q)
          StIdle: begin
            if (!iorq_s && armed_q) begin
              state_q   <= StAddr;
              cap_cnt_q <= 1'b0;
            end
          end
          // Address decode is done on the second capture edge after entry.
          StAddr: begin
            if (iorq_s) begin
              state_q <= StIdle;
            end else if (cap_cnt_q) begin
              if (al_q == PORT_LO) begin
                reg_addr <= ah_q;
                fiorge_n <= 1'b0;
                state_q  <= StHit;
              end else begin
                state_q <= StMiss;
              end
            end else begin
              cap_cnt_q <= 1'b1;
            end
          end
          StHit: begin
            if (iorq_s) begin
              state_q  <= StIdle;
              fiorge_n <= 1'b1;
            end else if (!rd_s) begin
              reg_rd  <= 1'b1;
              state_q <= StRdWait;
            end else if (!wr_s) begin
              state_q <= StWrWait;
            end
          end
          StRdWait: state_q <= StRdCap;
          StRdCap: begin
            zd_out  <= reg_rdata;
            zd_oe   <= 1'b1;
            state_q <= StRdHold;
          end
          StRdHold: begin
            if (iorq_s) begin
              state_q  <= StIdle;
              fiorge_n <= 1'b1;
              zd_oe    <= 1'b0;
            end else if (rd_s) begin
              state_q <= StEnd;
              zd_oe   <= 1'b0;
            end
          end
          StWrWait: begin
            reg_wdata <= zd_in;
            reg_wr    <= 1'b1;
            state_q   <= StEnd;
          end
          StMiss: if (iorq_s) state_q <= StIdle;
          StEnd: begin
            if (iorq_s) begin
              state_q  <= StIdle;
              fiorge_n <= 1'b1;
              zd_oe    <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/tsxb_fpga_zbus_slave.md
Name: tsxb_fpga_zbus_slave

Overview:
- FPGA-side endpoint of the TSXB CPLD ZX-BUS bridge for slave mode, where the host is bus master.
- Demultiplexes the 8-bit time-shared address bus (fa / fa_sel) into a 16-bit address and synchronises the host I/O strobes.
- Decodes one I/O port family and drives fiorge_n back to the CPLD, which sets the 16245 direction and the host IORGE.
- Presents a simple single-cycle register-file interface to FPGA internals.

Parameters:
PORT_LO, 8'hBF, low address byte that selects this block; the high byte is the register index.
SYNC_STAGES, 2, synchroniser depth for frd_n / fwr_n / fiorq_n (minimum 2).

Ports:
clk  input  1  50 MHz clock, same source as the CPLD clk50 that toggles fa_sel.
rst  input  1  asynchronous, active-high reset.
master_mode  input  1  1 = FPGA owns the bus (CPLD zbusak_n low); block forced idle.
fa  input  8  multiplexed host address from CPLD.
fa_sel  input  1  1 = fa carries za[15:8], 0 = za[7:0].
frd_n  input  1  host RD strobe (async).
fwr_n  input  1  host WR strobe (async).
fiorq_n  input  1  host IORQ strobe (async).
zd_in  input  8  host data bus, read side.
zd_out  output  8  data to host.
zd_oe  output  1  enables the zd_out pad driver.
fiorge_n  output  1  low = port decoded by FPGA.
reg_addr  output  8  register index (za[15:8]).
reg_wdata  output  8  write data.
reg_wr  output  1  one-clock write strobe.
reg_rd  output  1  one-clock read strobe.
reg_rdata  input  8  read data, valid one clock after reg_rd.

Behaviour:
- Reset values: fiorge_n=1, zd_oe=0, zd_out=0, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0; state IDLE.
- Address capture:
  - fa and fa_sel pass through one input register (synchronous source, no metastability handling).
  - Registered fa_sel=1 loads ah. Registered fa_sel=0 loads al.
- Strobes: SYNC_STAGES-deep synchronisers give rd_s, wr_s, iorq_s (active low).
- FSM:
  - IDLE: on iorq_s=0 and master_mode=0, go to ADDR, clear the capture counter.
  - ADDR: wait until two further clocks have elapsed so both halves are freshly captured; then go to DECODE. iorq_s=1 returns to IDLE.
  - DECODE: if al==PORT_LO, latch reg_addr<=ah, assert fiorge_n=0, go to HIT. Otherwise go to MISS.
  - HIT, read (rd_s=0): pulse reg_rd for 1 clock. Next clock zd_out<=reg_rdata and zd_oe=1. Go to RDHOLD.
  - HIT, write (wr_s=0): wait one extra clock for data settle, then reg_wdata<=zd_in and pulse reg_wr for 1 clock. Go to END.
  - HIT, neither strobe low: stay in HIT.
  - RDHOLD: zd_out is frozen; stay until rd_s=1 or iorq_s=1, then go to END.
  - MISS / END: wait for iorq_s=1, then go to IDLE.
  - Leaving HIT/RDHOLD/END for IDLE deasserts fiorge_n=1 and zd_oe=0 on the same registered edge.
- Exactly one reg_wr or reg_rd per host I/O cycle, never both.
- If rd_s and wr_s are both low in HIT, the read wins.
- Latency from fiorq_n falling at the pin to fiorge_n low: SYNC_STAGES+3 clocks, which is 5 clocks (100 ns) at defaults.
- Release: fiorge_n high and zd_oe low within SYNC_STAGES+1 clocks of fiorq_n rising.
- iorq_s rising in any state before DECODE completes aborts the cycle with no strobe and fiorge_n held at 1.
- master_mode=1 forces the FSM to IDLE on the next clock: fiorge_n=1, zd_oe=0, pending strobes suppressed. It takes effect in every state.
- Memory cycles are not decoded; only fiorq_n starts a cycle.
- rst asserted mid-cycle clears all outputs immediately. After rst release, if iorq_s is already low the block waits in IDLE only until iorq_s returns high, so no partial decode occurs.

Test Plan:
- I/O write 0x12BF, data 0xA5, WR held 300 ns -> fiorge_n low 5 clk after IORQ; single reg_wr pulse with reg_addr=0x12, reg_wdata=0xA5; fiorge_n high within 3 clk of IORQ release.
- I/O read 0x34BF, reg_rdata=0x5A -> single reg_rd pulse with reg_addr=0x34; zd_oe=1 and zd_out=0x5A until RD release; zd_oe=0 within 3 clk of release.
- I/O read 0x12FE (low byte mismatch) -> fiorge_n stays 1, zd_oe stays 0, no reg_rd or reg_wr.
- IORQ+WR to 0x12BF released after 3 clk -> no reg_wr and fiorge_n never low; next full write to 0x56BF with data 0x3C decodes correctly.
- rst pulsed during RDHOLD of a read from 0x01BF -> fiorge_n=1 and zd_oe=0 asynchronously; no reg_rd while IORQ remains low after rst release.
- master_mode=1 during a write to 0x12BF -> fiorge_n=1, no reg_wr; master_mode=0 then a read from 0x12BF -> normal response.
